// File: rtl/lego_ir_sched.sv
// Round-robin scheduler sharing one lego_ir Power Functions encoder between four channel slots.
// Optional periodic resend of active slots: define LEGO_IR_SCHED_REFRESH_EN.
module lego_ir_sched #(
    parameter int TICK_DIV   = 25000,
    parameter int GAP_MS     = 16,
    parameter int REPEAT     = 5,
    parameter int REFRESH_MS = 300
) (
    input  logic       clk_25m,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_ch,
    input  logic [3:0] wr_pwm_a,
    input  logic [3:0] wr_pwm_b,
    output logic       tx_start,
    output logic [1:0] tx_ch,
    output logic [3:0] tx_pwm_a,
    output logic [3:0] tx_pwm_b,
    input  logic       tx_busy,
    output logic [3:0] active
);

    localparam logic [31:0] DIV_LAST = 32'(TICK_DIV - 1);
    localparam logic [31:0] GMS_LAST = 32'(GAP_MS - 1);
    localparam logic [2:0]  REP_INIT = 3'(REPEAT);

    if (REPEAT < 1 || REPEAT > 7 || TICK_DIV < 1 || GAP_MS < 0 || REFRESH_MS < 1) begin : g_bad_cfg
        $error("lego_ir_sched: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_PICK, S_START, S_WAIT_HI, S_WAIT_LO, S_GAP
    } state_t;

    state_t      state_r, state_nx;
    logic [3:0]  slot_a_r [4];
    logic [3:0]  slot_b_r [4];
    logic [2:0]  rep_r    [4];
    logic [3:0]  active_r;
    logic [3:0]  pend_s;
    logic [1:0]  ptr_r;
    logic [1:0]  pick_s;
    logic        pick_found_s;
    logic        tx_start_r, start_nx;
    logic [1:0]  tx_ch_r;
    logic [3:0]  tx_pwm_a_r, tx_pwm_b_r;
    logic [1:0]  wait_r;
    logic [31:0] div_r, gms_r;
    logic        gap_done_s;
    logic        dec_s;
    logic        refresh_s;

`ifdef LEGO_IR_SCHED_REFRESH_EN
    localparam logic [31:0] REF_LAST = 32'(REFRESH_MS - 1);
    logic [31:0] ref_div_r, ref_ms_r;

    // Free-running ms prescaler and refresh period counter.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            ref_div_r <= 32'd0;
            ref_ms_r  <= 32'd0;
        end else if (ref_div_r == DIV_LAST) begin
            ref_div_r <= 32'd0;
            ref_ms_r  <= (ref_ms_r == REF_LAST) ? 32'd0 : ref_ms_r + 32'd1;
        end else begin
            ref_div_r <= ref_div_r + 32'd1;
        end
    end

    assign refresh_s = (ref_div_r == DIV_LAST) && (ref_ms_r == REF_LAST);
`else
    assign refresh_s = 1'b0;
`endif

    // Pending flags and first pending slot at or after the round-robin pointer.
    always_comb begin
        pick_s       = ptr_r;
        pick_found_s = 1'b0;
        for (int n = 0; n < 4; n++) begin
            pend_s[n] = (rep_r[n] != 3'd0);
        end
        for (int i = 0; i < 4; i++) begin
            if (!pick_found_s && pend_s[ptr_r + 2'(i)]) begin
                pick_s       = ptr_r + 2'(i);
                pick_found_s = 1'b1;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    assign gap_done_s = (div_r == DIV_LAST) && (gms_r == GMS_LAST);

    // Next-state, start pulse request and repetition consume.
    always_comb begin
        state_nx = state_r;
        start_nx = 1'b0;
        dec_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (|pend_s) state_nx = S_PICK;
                else         state_nx = S_IDLE;
            end
            S_PICK: begin
                state_nx = S_START;
                start_nx = !tx_busy;
            end
            S_START: begin
                // tx_start_r high means this is the pulse cycle
                if (tx_start_r) begin
                    state_nx = S_WAIT_HI;
                    dec_s    = 1'b1;
                end else begin
                    start_nx = !tx_busy;
                end
            end
            S_WAIT_HI: begin
                if (tx_busy)              state_nx = S_WAIT_LO;
                else if (wait_r == 2'd2)  state_nx = S_IDLE;
                else                      state_nx = S_WAIT_HI;
            end
            S_WAIT_LO: begin
                if (tx_busy)          state_nx = S_WAIT_LO;
                else if (GAP_MS == 0) state_nx = S_IDLE;
                else                  state_nx = S_GAP;
            end
            S_GAP: begin
                if (gap_done_s) state_nx = S_IDLE;
                else            state_nx = S_GAP;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM state, start pulse, presented command and round-robin pointer.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            tx_start_r <= 1'b0;
            tx_ch_r    <= 2'd0;
            tx_pwm_a_r <= 4'd0;
            tx_pwm_b_r <= 4'd0;
            ptr_r      <= 2'd0;
        end else begin
            state_r    <= state_nx;
            tx_start_r <= start_nx;
            if (state_r == S_PICK) begin
                tx_ch_r    <= pick_s;
                tx_pwm_a_r <= slot_a_r[pick_s];
                tx_pwm_b_r <= slot_b_r[pick_s];
                ptr_r      <= pick_s + 2'd1;
            end
        end
    end

    // Busy-rise timeout and inter-message gap counters, restarted outside their states.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            wait_r <= 2'd0;
            div_r  <= 32'd0;
            gms_r  <= 32'd0;
        end else begin
            wait_r <= (state_r == S_WAIT_HI) ? wait_r + 2'd1 : 2'd0;
            if (state_r != S_GAP) begin
                div_r <= 32'd0;
                gms_r <= 32'd0;
            end else if (div_r == DIV_LAST) begin
                div_r <= 32'd0;
                gms_r <= gms_r + 32'd1;
            end else begin
                div_r <= div_r + 32'd1;
            end
        end
    end

    // Command slots: a write re-arms and beats a same-cycle consume or refresh.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                slot_a_r[n] <= 4'd0;
                slot_b_r[n] <= 4'd0;
                rep_r[n]    <= 3'd0;
            end
            active_r <= 4'd0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (wr_en && wr_ch == 2'(n)) begin
                    slot_a_r[n] <= wr_pwm_a;
                    slot_b_r[n] <= wr_pwm_b;
                    rep_r[n]    <= REP_INIT;
                    active_r[n] <= ({wr_pwm_a, wr_pwm_b} != 8'd0);
                end else if (dec_s && tx_ch_r == 2'(n)) begin
                    rep_r[n] <= (rep_r[n] != 3'd0) ? rep_r[n] - 3'd1 : 3'd0;
                end else if (refresh_s && active_r[n] && rep_r[n] == 3'd0) begin
                    rep_r[n] <= REP_INIT;
                end
            end
        end
    end

    assign tx_start = tx_start_r;
    assign tx_ch    = tx_ch_r;
    assign tx_pwm_a = tx_pwm_a_r;
    assign tx_pwm_b = tx_pwm_b_r;
    assign active   = active_r;

endmodule

// File: tb/tb_lego_ir_sched.sv
// Directed self-checking bench for lego_ir_sched with a behavioural encoder model.
// Scaled timing: 10 cycles per ms so gaps and refresh periods stay short.
module tb_lego_ir_sched;

    localparam int TICK_DIV   = 10;
    localparam int GAP_MS     = 16;
    localparam int REPEAT     = 5;
    localparam int REFRESH_MS = 300;
    localparam int BUSY_LEN   = 20;
    localparam int GAP_CYC    = TICK_DIV * GAP_MS;

    logic       clk_25m;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [3:0] wr_pwm_a;
    logic [3:0] wr_pwm_b;
    logic       tx_start;
    logic [1:0] tx_ch;
    logic [3:0] tx_pwm_a;
    logic [3:0] tx_pwm_b;
    logic       tx_busy;
    logic [3:0] active;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_sends = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    bit         have_fall = 1'b0;
    int         gap_bad = 0;
    bit         enc_dead = 1'b0;
    logic [1:0] log_ch [64];
    logic [3:0] log_a  [64];
    logic [3:0] log_b  [64];
    int         log_cyc[64];

    lego_ir_sched #(
        .TICK_DIV  (TICK_DIV),
        .GAP_MS    (GAP_MS),
        .REPEAT    (REPEAT),
        .REFRESH_MS(REFRESH_MS)
    ) dut (
        .clk_25m (clk_25m),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_pwm_a(wr_pwm_a),
        .wr_pwm_b(wr_pwm_b),
        .tx_start(tx_start),
        .tx_ch   (tx_ch),
        .tx_pwm_a(tx_pwm_a),
        .tx_pwm_b(tx_pwm_b),
        .tx_busy (tx_busy),
        .active  (active)
    );

    initial begin
        clk_25m = 1'b0;
        forever #20 clk_25m = ~clk_25m;
    end

    initial begin
        forever begin
            @(posedge clk_25m);
            cyc = cyc + 1;
        end
    end

    initial begin
        repeat (60000) @(posedge clk_25m);
        $display("FAIL watchdog: run did not finish, got %0d cycles, required fewer", cyc);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Encoder model: logs every start, checks the gap, then holds busy for BUSY_LEN cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk_25m);
            if (rst_n && tx_start) begin
                if (n_sends < 64) begin
                    log_ch[n_sends]  = tx_ch;
                    log_a[n_sends]   = tx_pwm_a;
                    log_b[n_sends]   = tx_pwm_b;
                    log_cyc[n_sends] = cyc;
                end
                if (!enc_dead && have_fall && (cyc - fall_cyc) < GAP_CYC) gap_bad++;
                n_sends++;
                if (!enc_dead) begin
                    @(posedge clk_25m);
                    #1 tx_busy = 1'b1;
                    repeat (BUSY_LEN) @(posedge clk_25m);
                    #1 tx_busy = 1'b0;
                    fall_cyc  = cyc;
                    have_fall = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_ch    = 2'd0;
        wr_pwm_a = 4'd0;
        wr_pwm_b = 4'd0;
        repeat (3) @(negedge clk_25m);
        rst_n     = 1'b1;
        n_sends   = 0;
        have_fall = 1'b0;
        gap_bad   = 0;
        @(negedge clk_25m);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [3:0] a, input logic [3:0] b);
        wr_en    = 1'b1;
        wr_ch    = ch;
        wr_pwm_a = a;
        wr_pwm_b = b;
        @(negedge clk_25m);
        wr_en    = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int q = 0;
        int t = 0;
        while (q < 400 && t < 30000) begin
            @(negedge clk_25m);
            t++;
            if (tx_start || tx_busy) q = 0;
            else                     q++;
        end
        check_eq(tag, 32'(q >= 400), 32'd1);
    endtask

    task automatic wait_sends(input string tag, input int n);
        int t = 0;
        while (n_sends < n && t < 2000) begin
            @(negedge clk_25m);
            t++;
        end
        check_eq(tag, 32'(n_sends >= n), 32'd1);
    endtask

    initial begin
        int bad;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_ch    = 2'd0;
        wr_pwm_a = 4'd0;
        wr_pwm_b = 4'd0;

        // Test 1: reset values, latency, five sends of ch1 A=3 with full gaps
        do_reset();
        check_eq("rst_outputs", {tx_start, tx_ch, tx_pwm_a, tx_pwm_b, active}, 32'd0);
        wr(2'd1, 4'h3, 4'h0);
        check_eq("t1_active", 32'(active), 32'h2);
        check_eq("t1_no_early_start", 32'(tx_start), 32'd0);
        @(negedge clk_25m);
        check_eq("t1_no_start_c2", 32'(tx_start), 32'd0);
        @(negedge clk_25m);
        check_eq("t1_latency3", 32'(tx_start), 32'd1);
        check_eq("t1_first_cmd", {tx_ch, tx_pwm_a, tx_pwm_b}, {22'd0, 2'd1, 4'h3, 4'h0});
        wait_quiet("t1_quiet");
        check_eq("t1_sends", n_sends, 32'd5);
        bad = 0;
        for (int i = 0; i < n_sends && i < 64; i++)
            if (log_ch[i] != 2'd1 || log_a[i] != 4'h3 || log_b[i] != 4'h0) bad++;
        check_eq("t1_payload", bad, 32'd0);
        check_eq("t1_gap", gap_bad, 32'd0);

        // Test 2: ch0 and ch2 written back to back interleave 0,2,0,2,...
        do_reset();
        wr_en = 1'b1; wr_ch = 2'd0; wr_pwm_a = 4'h1; wr_pwm_b = 4'h2;
        @(negedge clk_25m);
        wr_ch = 2'd2; wr_pwm_a = 4'h4; wr_pwm_b = 4'h8;
        @(negedge clk_25m);
        wr_en = 1'b0;
        wait_quiet("t2_quiet");
        check_eq("t2_sends", n_sends, 32'd10);
        bad = 0;
        for (int i = 0; i < n_sends && i < 64; i++) begin
            if (i % 2 == 0) begin
                if (log_ch[i] != 2'd0 || log_a[i] != 4'h1 || log_b[i] != 4'h2) bad++;
            end else begin
                if (log_ch[i] != 2'd2 || log_a[i] != 4'h4 || log_b[i] != 4'h8) bad++;
            end
        end
        check_eq("t2_order", bad, 32'd0);
        check_eq("t2_gap", gap_bad, 32'd0);

        // Test 3: rewrite ch3 mid-transmission; in-flight value holds, rep reloads
        do_reset();
        wr(2'd3, 4'h5, 4'h0);
        wait_sends("t3_first", 1);
        repeat (5) @(negedge clk_25m);
        wr(2'd3, 4'h7, 4'h0);
        repeat (2) @(negedge clk_25m);
        check_eq("t3_inflight_a", 32'(tx_pwm_a), 32'h5);
        wait_quiet("t3_quiet");
        check_eq("t3_sends", n_sends, 32'd6);
        check_eq("t3_first_a", 32'(log_a[0]), 32'h5);
        bad = 0;
        for (int i = 1; i < n_sends && i < 64; i++)
            if (log_a[i] != 4'h7 || log_ch[i] != 2'd3) bad++;
        check_eq("t3_rest_a", bad, 32'd0);

        // Test 4: 0/0 write sends five stops, clears active and is never refreshed
        do_reset();
        wr(2'd0, 4'h2, 4'h2);
        wait_quiet("t4_quiet1");
        check_eq("t4_sends1", n_sends, 32'd5);
        wr(2'd0, 4'h0, 4'h0);
        check_eq("t4_active", 32'(active), 32'h0);
        wait_quiet("t4_quiet2");
        check_eq("t4_sends2", n_sends, 32'd10);
        bad = 0;
        for (int i = 5; i < n_sends && i < 64; i++)
            if (log_a[i] != 4'h0 || log_b[i] != 4'h0) bad++;
        check_eq("t4_stop_payload", bad, 32'd0);
        repeat (4000) @(negedge clk_25m);
        check_eq("t4_silent", n_sends, 32'd10);

        // Test 5: one active slot; refreshed every 300 ms only with the feature
        do_reset();
        wr(2'd1, 4'h9, 4'h1);
        wait_quiet("t5_quiet");
        check_eq("t5_sends1", n_sends, 32'd5);
        repeat (4000) @(negedge clk_25m);
`ifdef LEGO_IR_SCHED_REFRESH_EN
        check_eq("t5_refresh_burst", n_sends, 32'd10);
`else
        check_eq("t5_no_refresh", n_sends, 32'd5);
`endif

        // Test 6: encoder never goes busy; retry every 6 cycles until rep runs out
        do_reset();
        enc_dead = 1'b1;
        wr(2'd1, 4'h1, 4'h0);
        wait_quiet("t6_quiet");
        check_eq("t6_sends", n_sends, 32'd5);
        check_eq("t6_spacing_01", log_cyc[1] - log_cyc[0], 32'd6);
        check_eq("t6_spacing_34", log_cyc[4] - log_cyc[3], 32'd6);
        enc_dead = 1'b0;

        // Test 7: async reset mid-burst clears outputs at once and drops pending work
        do_reset();
        wr(2'd2, 4'h6, 4'h3);
        wait_sends("t7_two_sends", 2);
        repeat (3) @(negedge clk_25m);
        #5 rst_n = 1'b0;
        #1;
        check_eq("t7_async_clear", {tx_start, tx_ch, tx_pwm_a, tx_pwm_b, active}, 32'd0);
        repeat (3) @(negedge clk_25m);
        rst_n = 1'b1;
        wait_quiet("t7_quiet");
        check_eq("t7_no_more_sends", n_sends, 32'd2);
        check_eq("t7_active_after", 32'(active), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
